// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal segments,
// one register stage per segment, with a valid/ready stream and bubble collapsing.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   y,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    generate
        if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
        end
    endgenerate

    // Per-stage registers; b_q holds b already inverted for subtraction
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             c_q   [STAGES];
    logic             sub_q [STAGES];
    logic             ovf_q;

    // Stage inputs (previous stage or the input port) and next-state values
    logic             ld   [STAGES+1];
    logic             pv   [STAGES];
    logic [WIDTH-1:0] pa   [STAGES];
    logic [WIDTH-1:0] pb   [STAGES];
    logic [WIDTH-1:0] psum [STAGES];
    logic             pc   [STAGES];
    logic             psub [STAGES];
    logic [SEG:0]     seg  [STAGES];
    logic [WIDTH-1:0] nsum [STAGES];
    logic             nc   [STAGES];
    logic             novf;

    always_comb begin
        // Stage k may load when empty or when its occupant moves on this cycle
        ld[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            ld[k] = !v_q[k] || ld[k+1];
        end

        pv[0]   = in_valid;
        pa[0]   = a;
        pb[0]   = sub ? ~b : b;
        pc[0]   = sub;
        psub[0] = sub;
        psum[0] = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            pv[k]   = v_q[k-1];
            pa[k]   = a_q[k-1];
            pb[k]   = b_q[k-1];
            pc[k]   = c_q[k-1];
            psub[k] = sub_q[k-1];
            psum[k] = sum_q[k-1];
        end

        for (int k = 0; k < int'(STAGES); k++) begin
            seg[k]  = {1'b0, pa[k][k*SEG +: SEG]} + {1'b0, pb[k][k*SEG +: SEG]} + (SEG+1)'(pc[k]);
            nsum[k] = psum[k];
            nsum[k][k*SEG +: SEG] = seg[k][SEG-1:0];
            nc[k]   = seg[k][SEG];
        end

        // Operand signs agree (b already conditionally inverted) but result sign differs
        novf = (pa[LAST][WIDTH-1] == pb[LAST][WIDTH-1]) && (nsum[LAST][WIDTH-1] != pa[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (ld[k]) begin
                    v_q[k] <= pv[k];
                    // Data only moves with a valid token, so bubbles never disturb held fields
                    if (pv[k]) begin
                        a_q[k]   <= pa[k];
                        b_q[k]   <= pb[k];
                        sum_q[k] <= nsum[k];
                        sub_q[k] <= psub[k];
                        // Last stage keeps carry for add, borrow (inverted carry) for sub
                        c_q[k]   <= (k == int'(LAST)) ? (nc[k] ^ psub[k]) : nc[k];
                    end
                end
            end
            if (ld[LAST] && pv[LAST]) begin
                ovf_q <= novf;
            end
        end
    end

    assign in_ready  = rst_n && ld[0];
    assign out_valid = v_q[LAST];
    assign y         = {c_q[LAST], sum_q[LAST]};
    assign overflow  = ovf_q;

endmodule
